// File: rtl/dcache_pkg.sv
// dcache_pkg
//   Shared types and width helpers for the set-associative data cache.
//   - state_t : miss-handling FSM states (IDLE, WRITEBACK, FETCH)
//   - off_w / idx_w / tag_w : derive address field widths from the
//     cache geometry (WORDS and SETS must be powers of two, >= 2).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// dcache_way_store
//   Storage for one way of the cache: per-set valid, dirty, tag and a
//   block of WORDS data words.
//   Ports:
//     clk, reset          : clock, asynchronous active-low reset
//     index               : set selected for both read and write
//     valid, dirty,
//     tag_out, block_out  : combinational read of the selected set
//     word_we, offset,
//     word_data           : single-word store (marks the line dirty)
//     fill_we, fill_tag,
//     fill_block          : whole-block refill (line becomes valid, clean)
module dcache_way_store #(
  parameter int SETS   = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int OFF_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        index,
  output logic                    valid,
  output logic                    dirty,
  output logic [TAG_W-1:0]        tag_out,
  output logic [DATA_W*WORDS-1:0] block_out,
  input  logic                    word_we,
  input  logic [OFF_W-1:0]        offset,
  input  logic [DATA_W-1:0]       word_data,
  input  logic                    fill_we,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [DATA_W*WORDS-1:0] fill_block
);

  logic [SETS-1:0]         valid_bits;
  logic [SETS-1:0]         dirty_bits;
  logic [TAG_W-1:0]        tag_mem  [SETS];
  logic [DATA_W*WORDS-1:0] data_mem [SETS];

  // Only the status bits need reset; tag/data are meaningless while invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_we) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (word_we) begin
      dirty_bits[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_block;
    end else if (word_we) begin
      data_mem[index][offset*DATA_W +: DATA_W] <= word_data;
    end
  end

  assign valid     = valid_bits[index];
  assign dirty     = dirty_bits[index];
  assign tag_out   = tag_mem[index];
  assign block_out = data_mem[index];

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc
//   N-way (1 or 2) set-associative, write-back, write-allocate data cache
//   with LRU replacement (invalid ways are filled first).
//   Ports:
//     clk, reset            : clock, asynchronous active-low reset
//     read, write, address,
//     writedata             : CPU request, held until busywait is low
//     readdata, busywait    : load data (combinational on hit), CPU stall
//     mem_read, mem_write   : block fetch / write-back requests
//     mem_address           : block address {tag, index}
//     mem_writedata         : victim block on write-back (word 0 in LSBs)
//     mem_readdata          : fetched block (word 0 in LSBs)
//     mem_busywait          : memory busy; transfer done when sampled low
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           read,
  input  logic                           write,
  input  logic [ADDR_W-1:0]              address,
  input  logic [DATA_W-1:0]              writedata,
  output logic [DATA_W-1:0]              readdata,
  output logic                           busywait,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-off_w(WORDS)-1:0] mem_address,
  output logic [DATA_W*WORDS-1:0]        mem_writedata,
  input  logic [DATA_W*WORDS-1:0]        mem_readdata,
  input  logic                           mem_busywait
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS);
  localparam int BLK_W = DATA_W * WORDS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] index;
  logic [OFF_W-1:0] offset;

  assign tag    = address[ADDR_W-1 -: TAG_W];
  assign index  = address[OFF_W +: IDX_W];
  assign offset = address[OFF_W-1:0];

  state_t           state;
  logic [WAY_W-1:0] victim_reg;
  logic [SETS-1:0]  lru_reg;

  logic [WAYS-1:0]  way_valid;
  logic [WAYS-1:0]  way_dirty;
  logic [TAG_W-1:0] way_tag   [WAYS];
  logic [BLK_W-1:0] way_block [WAYS];
  logic [WAYS-1:0]  hit_way;
  logic [WAYS-1:0]  word_we;
  logic [WAYS-1:0]  fill_we;

  logic             req;
  logic             hit_any;
  logic             hit;
  logic [WAY_W-1:0] hit_idx;
  logic [WAY_W-1:0] victim;
  logic [BLK_W-1:0] hit_block;

  assign req = read | write;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      dcache_way_store #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .WORDS (WORDS),
        .OFF_W (OFF_W)
      ) u_store (
        .clk       (clk),
        .reset     (reset),
        .index     (index),
        .valid     (way_valid[gi]),
        .dirty     (way_dirty[gi]),
        .tag_out   (way_tag[gi]),
        .block_out (way_block[gi]),
        .word_we   (word_we[gi]),
        .offset    (offset),
        .word_data (writedata),
        .fill_we   (fill_we[gi]),
        .fill_tag  (tag),
        .fill_block(mem_readdata)
      );

      assign hit_way[gi] = way_valid[gi] && (way_tag[gi] == tag);
      // read && write together behaves as a store.
      assign word_we[gi] = write && hit && (hit_idx == WAY_W'(gi));
      // Refill lands on the edge where the memory reports completion.
      assign fill_we[gi] = (state == FETCH) && !mem_busywait && (victim_reg == WAY_W'(gi));
    end
  endgenerate

  always_comb begin
    hit_any = |hit_way;
    hit_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_way[w]) hit_idx = WAY_W'(w);
    end
    // Lowest-index invalid way wins; otherwise the LRU way.
    victim = (WAYS > 1) ? WAY_W'(lru_reg[index]) : '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  assign hit       = req && hit_any && (state == IDLE);
  assign busywait  = req && !hit;
  assign hit_block = way_block[hit_idx];
  assign readdata  = hit ? hit_block[offset*DATA_W +: DATA_W] : '0;

  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      WRITEBACK: begin
        mem_address   = {way_tag[victim_reg], index};
        mem_writedata = way_block[victim_reg];
      end
      FETCH: mem_address = {tag, index};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      victim_reg <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      lru_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (WAYS > 1) lru_reg[index] <= ~hit_idx[0];
          end else if (req) begin
            victim_reg <= victim;
            if (way_valid[victim] && way_dirty[victim]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state    <= FETCH;
              mem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state     <= FETCH;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            if (WAYS > 1) lru_reg[index] <= ~victim_reg[0];
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
